// File: rtl/riscv_pkg.sv
// Shared definitions for the core debug controller: FSM state encoding,
// the default drain length and the channel-select width helper.
package riscv_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED, ST_STEP} dbg_state_e;

    localparam int DRAIN_DEFAULT = 4;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/core_debug_ctrl_if.sv
// Debug request/observation bundle between the debug host and the core debug controller.
interface core_debug_ctrl_if
    import riscv_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 32
);
    localparam int SW = sel_w(NCH);

    logic                    halt_req;
    logic                    resume;
    logic                    step;
    logic                    prog;
    logic                    trap_in;
    logic [SW-1:0]           ch_sel;
    logic [NCH-1:0][DW-1:0]  ch_data;
    logic                    dbg;
    logic                    halted;
    logic                    trap_flag;
    logic [DW-1:0]           debug_output;
    logic [15:0]             step_cnt;

    modport master (
        output halt_req, resume, step, prog, trap_in, ch_sel, ch_data,
        input  dbg, halted, trap_flag, debug_output, step_cnt
    );

    modport slave (
        input  halt_req, resume, step, prog, trap_in, ch_sel, ch_data,
        output dbg, halted, trap_flag, debug_output, step_cnt
    );
endinterface

// File: rtl/dbg_ch_mux.sv
// Combinational debug channel selector; out-of-range selects read as zero.
module dbg_ch_mux #(
    parameter int NCH = 4,
    parameter int DW  = 32,
    parameter int SW  = 2
) (
    input  logic [NCH-1:0][DW-1:0] i_data,
    input  logic [SW-1:0]          i_sel,
    output logic [DW-1:0]          o_data
);
    always_comb begin
        o_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (i_sel == SW'(i)) o_data = i_data[i];
        end
    end
endmodule

// File: rtl/core_debug_ctrl.sv
// Core debug controller: halt/drain/step FSM, sticky trap flag, step counter
// and a registered view of one selected observation channel.
module core_debug_ctrl
    import riscv_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = 32,
    parameter int DRAIN = DRAIN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    core_debug_ctrl_if.slave  bus
);
    localparam int SW = sel_w(NCH);

    dbg_state_e     r_state;
    logic [3:0]     r_cnt;
    logic           r_dbg;
    logic           r_halted;
    logic           r_trap;
    logic [15:0]    r_step_cnt;
    logic [DW-1:0]  r_dout;
    logic [DW-1:0]  w_mux;
    logic           w_resume_go;

    dbg_ch_mux #(.NCH(NCH), .DW(DW), .SW(SW)) u_mux (
        .i_data (bus.ch_data),
        .i_sel  (bus.ch_sel),
        .o_data (w_mux)
    );

    assign w_resume_go = (r_state == ST_HALTED) && bus.resume && !bus.halt_req;

    // dbg/halted are registered from the state being entered, so they track r_state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_dbg      <= 1'b0;
            r_halted   <= 1'b0;
            r_trap     <= 1'b0;
            r_step_cnt <= '0;
            r_dout     <= '0;
        end else begin
            r_dout   <= w_mux;
            r_dbg    <= bus.prog;
            r_halted <= 1'b0;
            if (bus.trap_in)      r_trap <= 1'b1;
            else if (w_resume_go) r_trap <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (bus.halt_req || bus.trap_in) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= 4'(DRAIN - 1);
                        r_dbg   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Leave as the count reaches zero; a zero load (DRAIN=1) leaves at once.
                    r_dbg <= 1'b1;
                    r_cnt <= (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
                    if (r_cnt <= 4'd1) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (w_resume_go) begin
                        r_state    <= ST_RUN;
                        r_step_cnt <= '0;
                    end else if (bus.step) begin
                        r_state <= ST_STEP;
                    end else begin
                        r_dbg    <= 1'b1;
                        r_halted <= 1'b1;
                    end
                end
                ST_STEP: begin
                    r_state  <= ST_HALTED;
                    r_dbg    <= 1'b1;
                    r_halted <= 1'b1;
                    if (r_step_cnt != 16'hFFFF) r_step_cnt <= r_step_cnt + 16'd1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.dbg          = r_dbg;
    assign bus.halted       = r_halted;
    assign bus.trap_flag    = r_trap;
    assign bus.step_cnt     = r_step_cnt;
    assign bus.debug_output = r_dout;
endmodule

// File: doc/core_debug_ctrl.md
CORE_DEBUG_CTRL -- requirements
Module: core_debug_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of debug observation channels, range 1..8.
REQ-002 Parameter DW, default 32: channel and debug_output data width.
REQ-003 Parameter DRAIN, default 4: pipeline drain cycles before the halt is reported, range 1..15.
REQ-004 clk  in  1  single system clock; all state is updated on its rising edge.
REQ-005 Rst_n  in  1  asynchronous, active-low reset.
REQ-006 halt_req  in  1  level request to stop the core pipeline.
REQ-007 resume  in  1  single-cycle pulse; returns a halted core to run.
REQ-008 step  in  1  single-cycle pulse; executes one pipeline-advance cycle while halted.
REQ-009 prog  in  1  instruction-memory programming mode; forces a stall regardless of state.
REQ-010 trap_in  in  1  single-cycle trap event from the core.
REQ-011 ch_sel  in  $clog2(NCH) (min 1)  selects the observed channel.
REQ-012 ch_data  in  NCH x DW  packed channel data (for example instruction, rs1 readout, PC).
REQ-013 dbg  out  1  pipeline stall to all stages.
REQ-014 halted  out  1  high while in HALTED.
REQ-015 trap_flag  out  1  sticky trap indicator.
REQ-016 debug_output  out  DW  registered view of the selected channel.
REQ-017 step_cnt  out  16  number of steps completed since the last resume.

Function
REQ-018 The controller SHALL be a four-state FSM: RUN, DRAIN, HALTED, STEP.
REQ-019 RUN: halt_req=1 or trap_in=1 SHALL transition to DRAIN and load the drain counter with DRAIN-1.
REQ-020 DRAIN: the counter SHALL decrement each cycle; at 0 the FSM SHALL transition to HALTED.
REQ-021 HALTED: step=1 SHALL transition to STEP. resume=1 with halt_req=0 SHALL transition to RUN. If both are asserted, resume SHALL win.
REQ-022 HALTED: resume=1 while halt_req=1 SHALL be ignored and the FSM SHALL stay HALTED.
REQ-023 STEP SHALL last exactly one cycle, increment step_cnt (saturating at 16'hFFFF), then return to HALTED.
REQ-024 dbg SHALL be a registered output equal to 1 in DRAIN and HALTED, 0 in RUN and STEP, and SHALL be forced to 1 whenever prog=1.
REQ-025 halted SHALL equal 1 exactly in state HALTED.
REQ-026 trap_flag SHALL be set on trap_in and cleared on the RUN transition caused by resume. If trap_in and the clear occur in the same cycle, set SHALL win.
REQ-027 A trap_in in DRAIN, HALTED or STEP SHALL only set trap_flag and SHALL NOT restart the drain.
REQ-028 step_cnt SHALL clear to 0 on every HALTED->RUN transition.
REQ-029 debug_output SHALL be updated every cycle to ch_data[ch_sel], giving a latency of 1 cycle.
REQ-030 A ch_sel value >= NCH SHALL produce debug_output = 0.
REQ-031 Pulses of step or resume arriving in RUN, DRAIN or STEP SHALL be ignored.

Reset
REQ-032 Rst_n=0 SHALL asynchronously force: state RUN, dbg=0, halted=0, trap_flag=0, step_cnt=0, debug_output=0, drain counter=0.
REQ-033 Reset asserted in any state SHALL abort that state with no residual step or drain. After release, operation SHALL resume from RUN on the next edge.

Structure
REQ-034 The FSM state enum and the DRAIN default SHALL live in the shared package riscv_pkg.
REQ-035 The channel multiplexer SHALL be one sub-module, dbg_ch_mux, parametrised by NCH and DW and purely combinational.
REQ-036 The FSM, counters and output registers SHALL reside in core_debug_ctrl.

Verification
REQ-037 Halt latency: with DRAIN=4, assert halt_req at cycle 10 -> dbg=1 from cycle 11, halted=1 at cycle 14.
REQ-038 Single step: halted, pulse step -> dbg=0 for exactly one cycle, step_cnt=1. Three more steps -> step_cnt=4.
REQ-039 Resume precedence: halted, step=resume=1 with halt_req=0 -> RUN, step_cnt=0, no STEP cycle.
REQ-040 Trap: trap_in in RUN -> trap_flag=1 and halt after DRAIN cycles. trap_in coincident with resume -> trap_flag stays 1.
REQ-041 Mux: NCH=4, ch_data[2]=32'hDEADBEEF, ch_sel=2 -> debug_output=32'hDEADBEEF one cycle later. ch_sel=5 with NCH=5 parameter variant set to 4 -> 0.
REQ-042 Reset: Rst_n low mid-DRAIN, asynchronously and not on a clock edge -> all outputs 0 immediately. prog=1 in RUN -> dbg=1 while state stays RUN.
